fc_feature_streamer: RTL and testbench
======================================

FC_FEATURE_STREAMER -- requirements
Module: fc_feature_streamer

Interface
REQ-001 SHALL have parameter N_FEAT, default 64, number of signed 8-bit features per frame (multiple of LANES).
REQ-002 SHALL have parameter LANES, default 4, features presented per streaming beat.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 32, WAIT-state cycle limit (used only under FS_TIMEOUT_EN).
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port feat_valid  in  1  upstream feature valid.
REQ-007 SHALL have port feat_data  in  8  signed feature value.
REQ-008 SHALL have port feat_ready  out  1  streamer accepts a feature this cycle.
REQ-009 SHALL have port fc_en  out  1  enable to downstream FC layer.
REQ-010 SHALL have port fc_in  out  LANES x 8  packed signed beat; lane 0 at bits [7:0].
REQ-011 SHALL have port fc_flag  in  1  FC result ready.
REQ-012 SHALL have port fc_class  in  2  FC class index.
REQ-013 SHALL have port class_valid  out  1  one-cycle result strobe.
REQ-014 SHALL have port class_out  out  2  captured class index.
REQ-015 SHALL have port busy  out  1  high in any state other than FILL.
REQ-016 SHALL have port timeout_err  out  1  one-cycle timeout strobe (tied 0 without FS_TIMEOUT_EN).

Function
REQ-017 SHALL implement states FILL, STREAM, WAIT, DONE with all outputs registered.
REQ-018 In FILL, feat_ready SHALL be 1; a feature SHALL be written to buf[wr_ptr] and wr_ptr incremented on each feat_valid&&feat_ready cycle.
REQ-019 When the N_FEAT-th feature is accepted, wr_ptr SHALL wrap to 0 and state SHALL move to STREAM next cycle; feat_ready SHALL be 0 in that STREAM cycle.
REQ-020 feat_valid outside FILL SHALL be ignored with no buffer write.
REQ-021 In STREAM, fc_en SHALL be 1 and fc_in lane j of beat b SHALL equal buf[b*LANES+j], b = 0..N_FEAT/LANES-1, one beat per cycle, no stalls.
REQ-022 After the last beat (b=15 at defaults), state SHALL move to WAIT; fc_en SHALL stay 1 and fc_in SHALL be all zeros in WAIT.
REQ-023 In WAIT, on fc_flag==1 the streamer SHALL capture fc_class into class_out and move to DONE.
REQ-024 In DONE, fc_en SHALL be 0 for exactly one cycle (clearing the FC accumulators), class_valid SHALL be 1 for that cycle, then state SHALL return to FILL.
REQ-025 Latency: last feature accepted at cycle T -> beats at T+1..T+16, earliest WAIT at T+17, class_valid at T+18 when fc_flag is high at T+17, feat_ready high again at T+19.
REQ-026 fc_flag asserted in FILL or STREAM SHALL be ignored.
REQ-027 class_out SHALL hold its value until the next capture.

Reset
REQ-028 On rst, state SHALL be FILL, wr_ptr and beat counter 0, buffer contents unspecified.
REQ-029 On rst, feat_ready=1 after release, fc_en=0, fc_in=0, class_valid=0, class_out=0, busy=0, timeout_err=0.
REQ-030 rst mid-FILL or mid-STREAM SHALL discard the partial frame; the next frame starts at buf[0].

Configuration
REQ-031 With FS_TIMEOUT_EN defined, a WAIT counter SHALL count from 0; if TIMEOUT_CYC cycles elapse in WAIT without fc_flag, timeout_err SHALL pulse 1 cycle, state SHALL go to DONE with class_valid held 0, and class_out SHALL be unchanged.
REQ-032 Without FS_TIMEOUT_EN, WAIT SHALL persist until fc_flag and timeout_err SHALL be constant 0.

Verification
REQ-033 64 features valued 0..63 back-to-back -> 16 beats with beat 0 fc_in lanes {3,2,1,0} (lane 3 high) and beat 15 lanes {63,62,61,60}, fc_en high 16 cycles.
REQ-034 fc_flag=1, fc_class=1 at first WAIT cycle -> class_valid=1, class_out=1 at T+18, fc_en=0 that cycle, feat_ready=1 at T+19.
REQ-035 feat_valid toggled every other cycle with features -128 and 127 alternating -> buffer holds exactly 64 accepted values, beat 0 lanes {127,-128,127,-128}.
REQ-036 rst asserted after 30 features accepted, then 64 features 1..64 -> beat 0 lanes {4,3,2,1}, no residue of old frame.
REQ-037 FS_TIMEOUT_EN defined, fc_flag held 0 -> timeout_err pulses at WAIT cycle 32, class_valid stays 0, next FILL accepts features.
REQ-038 fc_flag=1 held during FILL and STREAM -> no class_valid until WAIT reached.

Source files
------------

// File: rtl/fc_feature_streamer.sv
// rtl/fc_feature_streamer.sv - feature frame buffer streaming LANES-wide beats into an FC layer
// Optional feature: define FS_TIMEOUT_EN to abort a WAIT that lasts TIMEOUT_CYC cycles.

module fc_feature_streamer #(
  parameter int N_FEAT      = 64,
  parameter int LANES       = 4,
  parameter int TIMEOUT_CYC = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               feat_valid,
  input  logic [7:0]         feat_data,
  output logic               feat_ready,
  output logic               fc_en,
  output logic [LANES*8-1:0] fc_in,
  input  logic               fc_flag,
  input  logic [1:0]         fc_class,
  output logic               class_valid,
  output logic [1:0]         class_out,
  output logic               busy,
  output logic               timeout_err
);

  localparam int NB     = N_FEAT / LANES;
  localparam int PTR_W  = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
  localparam int BEAT_W = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    S_FILL,
    S_STREAM,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   wr_ptr;
  logic [BEAT_W-1:0]  beat_cnt;
  logic [7:0]         feat_buf [N_FEAT];

  logic               wr_en;
  logic               last_feat;
  logic               last_beat;
  logic [BEAT_W-1:0]  rd_beat;
  logic [PTR_W-1:0]   rd_base;
  logic [LANES*8-1:0] next_beat;

`ifdef FS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
`endif

  // Features are only taken while filling; feat_ready is high exactly in FILL.
  assign wr_en     = (state == S_FILL) && feat_valid;
  assign last_feat = wr_en && (wr_ptr == PTR_W'(N_FEAT - 1));
  assign last_beat = (beat_cnt == BEAT_W'(NB - 1));

  // Frame buffer write port; contents need no reset since a frame always refills from index 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      feat_buf[wr_ptr] <= feat_data;
    end
  end

  // Assemble the beat to present next cycle: beat 0 when the frame completes, else the following beat.
  // The final feature is forwarded directly in case it lands in beat 0 (single-beat frames).
  always_comb begin
    next_beat = '0;
    rd_beat   = (state == S_STREAM) ? beat_cnt + BEAT_W'(1) : '0;
    rd_base   = PTR_W'(rd_beat) * PTR_W'(LANES);
    for (int j = 0; j < LANES; j++) begin
      if (last_feat && ((rd_base + PTR_W'(j)) == wr_ptr)) begin
        next_beat[j*8 +: 8] = feat_data;
      end else begin
        next_beat[j*8 +: 8] = feat_buf[rd_base + PTR_W'(j)];
      end
    end
  end

  // Control FSM with every output registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_FILL;
      wr_ptr      <= '0;
      beat_cnt    <= '0;
      feat_ready  <= 1'b1;
      fc_en       <= 1'b0;
      fc_in       <= '0;
      class_valid <= 1'b0;
      class_out   <= 2'd0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
`ifdef FS_TIMEOUT_EN
      wait_cnt    <= '0;
`endif
    end else begin
      class_valid <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        S_FILL: begin
          if (wr_en) begin
            if (last_feat) begin
              wr_ptr     <= '0;
              beat_cnt   <= '0;
              state      <= S_STREAM;
              feat_ready <= 1'b0;
              busy       <= 1'b1;
              fc_en      <= 1'b1;
              fc_in      <= next_beat;
            end else begin
              wr_ptr <= wr_ptr + PTR_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (last_beat) begin
            state    <= S_WAIT;
            beat_cnt <= '0;
            fc_in    <= '0;
`ifdef FS_TIMEOUT_EN
            wait_cnt <= '0;
`endif
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
            fc_in    <= next_beat;
          end
        end
        S_WAIT: begin
          if (fc_flag) begin
            class_out   <= fc_class;
            class_valid <= 1'b1;
            fc_en       <= 1'b0;
            state       <= S_DONE;
          end
`ifdef FS_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_err <= 1'b1;
            fc_en       <= 1'b0;
            state       <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + TO_W'(1);
          end
`endif
        end
        S_DONE: begin
          state      <= S_FILL;
          feat_ready <= 1'b1;
          busy       <= 1'b0;
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_feature_streamer.sv
// tb/tb_fc_feature_streamer.sv - self-checking bench for fc_feature_streamer

module tb_fc_feature_streamer;

  localparam int N_FEAT      = 64;
  localparam int LANES       = 4;
  localparam int TIMEOUT_CYC = 32;
  localparam int NB          = N_FEAT / LANES;
`ifdef FS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               feat_valid = 1'b0;
  logic [7:0]         feat_data = 8'd0;
  logic               feat_ready;
  logic               fc_en;
  logic [LANES*8-1:0] fc_in;
  logic               fc_flag = 1'b0;
  logic [1:0]         fc_class = 2'd0;
  logic               class_valid;
  logic [1:0]         class_out;
  logic               busy;
  logic               timeout_err;

  int tests = 0;
  int fails = 0;

  fc_feature_streamer #(
    .N_FEAT(N_FEAT),
    .LANES(LANES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .feat_valid(feat_valid),
    .feat_data(feat_data),
    .feat_ready(feat_ready),
    .fc_en(fc_en),
    .fc_in(fc_in),
    .fc_flag(fc_flag),
    .fc_class(fc_class),
    .class_valid(class_valid),
    .class_out(class_out),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: timeline of the current frame measured from the cycle its last feature was taken.
  logic [7:0]         m_frame [N_FEAT];
  int                 m_cnt = 0;
  int                 cyc = 0;
  int                 t_last = -1;
  int                 t_done = -1;
  bit                 done_cv = 1'b0;
  bit                 m_valid = 1'b0;
  logic               e_ready, e_en, e_cv, e_busy, e_to;
  logic [1:0]         e_class = 2'd0;
  logic [LANES*8-1:0] e_in;

  always @(posedge clk) begin
    int d;
    if (rst) begin
      m_valid = 1'b0;
      m_cnt   = 0;
      t_last  = -1;
      t_done  = -1;
      e_class = 2'd0;
    end else begin
      m_valid = 1'b1;
      if (t_last < 0) begin
        if (feat_valid) begin
          m_frame[m_cnt] = feat_data;
          m_cnt++;
          if (m_cnt == N_FEAT) begin
            m_cnt  = 0;
            t_last = cyc;
          end
        end
      end else if (t_done < 0) begin
        d = cyc - t_last;
        if (d > NB) begin
          if (fc_flag) begin
            t_done  = cyc + 1;
            done_cv = 1'b1;
            e_class = fc_class;
          end else if (TO_EN && (d - NB) == TIMEOUT_CYC) begin
            t_done  = cyc + 1;
            done_cv = 1'b0;
          end
        end
      end else if (cyc == t_done) begin
        t_last = -1;
        t_done = -1;
      end
    end
    cyc++;
    e_in = '0;
    e_cv = 1'b0;
    e_to = 1'b0;
    if (t_last < 0) begin
      e_ready = 1'b1; e_en = 1'b0; e_busy = 1'b0;
    end else if (t_done >= 0) begin
      e_ready = 1'b0; e_en = 1'b0; e_busy = 1'b1;
      e_cv = done_cv;
      e_to = !done_cv;
    end else begin
      d = cyc - t_last;
      e_ready = 1'b0; e_en = 1'b1; e_busy = 1'b1;
      if (d >= 1 && d <= NB) begin
        for (int j = 0; j < LANES; j++) e_in[j*8 +: 8] = m_frame[(d-1)*LANES + j];
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      chk("feat_ready", feat_ready, e_ready);
      chk("fc_en", fc_en, e_en);
      chk("fc_in", fc_in, e_in);
      chk("class_valid", class_valid, e_cv);
      chk("class_out", class_out, e_class);
      chk("busy", busy, e_busy);
      chk("timeout_err", timeout_err, e_to);
    end
  end

  task automatic drive_feature(input logic [7:0] v);
    feat_valid = 1'b1;
    feat_data  = v;
    @(negedge clk);
    feat_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_feat_ready", feat_ready, 1'b1);
    chk("rst_fc_en", fc_en, 1'b0);
    chk("rst_fc_in", fc_in, '0);
    chk("rst_class_valid", class_valid, 1'b0);
    chk("rst_class_out", class_out, 2'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_timeout_err", timeout_err, 1'b0);
    #1 rst = 1'b0;

    // Ramp frame 0..63 back-to-back, class captured on first WAIT cycle.
    @(negedge clk);
    for (int i = 0; i < N_FEAT; i++) drive_feature(8'(i));
    chk("ramp_beat0", fc_in, 32'h03020100);
    chk("ramp_en_first", fc_en, 1'b1);
    chk("ramp_ready_low", feat_ready, 1'b0);
    repeat (15) @(negedge clk);
    chk("ramp_beat15", fc_in, 32'h3f3e3d3c);
    chk("ramp_en_last", fc_en, 1'b1);
    @(negedge clk);
    chk("wait_en", fc_en, 1'b1);
    chk("wait_in_zero", fc_in, '0);
    fc_flag  = 1'b1;
    fc_class = 2'd1;
    @(negedge clk);
    fc_flag = 1'b0;
    chk("done_class_valid", class_valid, 1'b1);
    chk("done_class_out", class_out, 2'd1);
    chk("done_en_low", fc_en, 1'b0);
    @(negedge clk);
    chk("refill_ready", feat_ready, 1'b1);
    chk("refill_class_hold", class_out, 2'd1);

    // Sparse alternating extremes with fc_flag held through FILL and STREAM.
    fc_flag  = 1'b1;
    fc_class = 2'd2;
    for (int i = 0; i < N_FEAT; i++) begin
      if (i != 0) begin
        feat_data = 8'h33;
        @(negedge clk);
      end
      drive_feature((i % 2 == 0) ? 8'h80 : 8'h7f);
    end
    chk("alt_beat0", fc_in, 32'h7f807f80);
    chk("alt_no_early_cv", class_valid, 1'b0);
    repeat (17) @(negedge clk);
    chk("alt_class_valid", class_valid, 1'b1);
    chk("alt_class_out", class_out, 2'd2);
    fc_flag = 1'b0;
    @(negedge clk);

    // Reset mid-FILL discards the partial frame; feat_valid during STREAM is ignored.
    for (int i = 0; i < 30; i++) drive_feature(8'haa);
    do_reset();
    @(negedge clk);
    for (int i = 1; i <= N_FEAT; i++) drive_feature(8'(i));
    chk("rst_frame_beat0", fc_in, 32'h04030201);
    feat_valid = 1'b1;
    feat_data  = 8'h55;
    repeat (16) @(negedge clk);
    feat_valid = 1'b0;
    fc_flag    = 1'b1;
    fc_class   = 2'd3;
    @(negedge clk);
    fc_flag = 1'b0;
    chk("rst_frame_cv", class_valid, 1'b1);
    chk("rst_frame_class", class_out, 2'd3);
    @(negedge clk);

`ifdef FS_TIMEOUT_EN
    // No fc_flag: WAIT times out, class_out keeps its last value.
    for (int i = 0; i < N_FEAT; i++) drive_feature(8'(i * 3));
    repeat (16 + TIMEOUT_CYC) @(negedge clk);
    chk("to_pulse", timeout_err, 1'b1);
    chk("to_no_cv", class_valid, 1'b0);
    chk("to_class_hold", class_out, 2'd3);
    @(negedge clk);
    chk("to_refill_ready", feat_ready, 1'b1);
`endif

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      feat_valid = ($urandom_range(0, 3) != 0);
      feat_data  = 8'($urandom);
      fc_flag    = ($urandom_range(0, 5) == 0);
      fc_class   = 2'($urandom);
      if ($urandom_range(0, 699) == 0) begin
        do_reset();
      end
      @(negedge clk);
    end
    feat_valid = 1'b0;
    fc_flag    = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
